// File: rtl/seq_det_pkg.sv
// Shared definitions for the parametrised serial sequence detector:
// FSM state encoding and default sizing/pattern constants.
package seq_det_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    ARMED = 2'd1,
    HIT   = 2'd2
  } state_t;

  localparam int          PAT_W_DEF   = 4;
  localparam int          CNT_W_DEF   = 8;
  localparam logic [3:0]  PAT_RST_DEF = 4'b1101;

endpackage

// File: rtl/seq_mask_cmp.sv
// Masked equality of the candidate history word against the loaded pattern.
// A mask bit of 1 makes the corresponding position a don't-care.
module seq_mask_cmp #(
  parameter int PAT_W = 4
) (
  input  logic [PAT_W-1:0] nxt,
  input  logic [PAT_W-1:0] pat,
  input  logic [PAT_W-1:0] mask,
  output logic             eq
);

  assign eq = (((nxt ^ pat) & ~mask) == '0);

endmodule

// File: rtl/seq_detector_param.sv
// Run-time programmable serial sequence detector with overlapping/non-overlapping
// detection, saturating match counter and a registered one-cycle match pulse.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = PAT_W_DEF,
  parameter int               CNT_W   = CNT_W_DEF,
  parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(PAT_RST_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             x_valid,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic [PAT_W-1:0] mask_in,
  input  logic             clr,
  output logic             z,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int                FILL_W    = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_ARM  = FILL_W'(PAT_W - 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  state_t             state, state_nxt;
  logic [PAT_W-1:0]   hist, hist_nxt;
  logic [PAT_W-1:0]   pat, pat_nxt;
  logic [PAT_W-1:0]   mask, mask_nxt;
  logic [FILL_W-1:0]  fill, fill_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [PAT_W-1:0]   nxt;
  logic               cmp_eq;
  logic               hit;

  assign nxt = {hist[PAT_W-2:0], x};

  seq_mask_cmp #(.PAT_W(PAT_W)) u_cmp (
    .nxt  (nxt),
    .pat  (pat),
    .mask (mask),
    .eq   (cmp_eq)
  );

  // A match needs enough history that this bit completes a full window.
  assign hit = x_valid && (fill >= FILL_ARM) && cmp_eq;

  always_comb begin
    hist_nxt  = hist;
    pat_nxt   = pat;
    mask_nxt  = mask;
    fill_nxt  = fill;
    cnt_nxt   = cnt;
    state_nxt = FILL;

    if (clr) begin
      hist_nxt = '0;
      fill_nxt = '0;
      cnt_nxt  = '0;
    end else if (pat_load) begin
      pat_nxt  = pat_in;
      mask_nxt = mask_in;
      hist_nxt = '0;
      fill_nxt = '0;
    end else if (x_valid) begin
      hist_nxt = nxt;
      fill_nxt = (fill == FILL_FULL) ? fill : fill + FILL_W'(1);
      if (hit) begin
        if (cnt != '1) cnt_nxt = cnt + CNT_W'(1);
        if (!overlap) fill_nxt = '0;
      end
    end

    // HIT drives z; otherwise the state just mirrors whether the next bit can match.
    if (!clr && !pat_load && hit) begin
      state_nxt = HIT;
    end else if (fill_nxt >= FILL_ARM) begin
      state_nxt = ARMED;
    end else begin
      state_nxt = FILL;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= FILL;
      hist  <= '0;
      fill  <= '0;
      pat   <= PAT_RST;
      mask  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      hist  <= hist_nxt;
      fill  <= fill_nxt;
      pat   <= pat_nxt;
      mask  <= mask_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign z         = (state == HIT);
  assign match_cnt = cnt;
  assign cnt_sat   = &cnt;

endmodule
